// File: rtl/blackjack_display_writer_if.sv
`default_nettype none
// ============================================================================
// Module      : blackjack_display_writer_if
// Description : Request and glyph-buffer write port bundle for the blackjack
//               display writer. The master modport is the writer itself: it
//               takes requests and drives the glyph-buffer write port. The
//               slave modport is the requesting logic / glyph buffer side.
// Revision    : 1.0 - initial release
// ============================================================================
interface blackjack_display_writer_if #(
    parameter int TOTAL_W = 5,
    parameter int GLYPH_W = 5
);
    logic               req;
    logic [2:0]         msg_sel;
    logic [TOTAL_W-1:0] player_total;
    logic [TOTAL_W-1:0] dealer_total;
    logic               busy;
    logic               done;
    logic               wr_en;
    logic [2:0]         wr_addr;
    logic [GLYPH_W-1:0] wr_data;

    modport master (
        input  req, msg_sel, player_total, dealer_total,
        output busy, done, wr_en, wr_addr, wr_data
    );

    modport slave (
        output req, msg_sel, player_total, dealer_total,
        input  busy, done, wr_en, wr_addr, wr_data
    );
endinterface
`default_nettype wire

// File: rtl/blackjack_display_writer.sv
`default_nettype none
// ============================================================================
// Module      : blackjack_display_writer
// Description : Turns a display request (message select + hand totals) into
//               eight glyph codes and writes them one slot per cycle into the
//               8-digit display's glyph buffer. Totals are split into tens and
//               units with a fixed three-step subtract-10 loop.
// Revision    : 1.0 - initial release
// ============================================================================
module blackjack_display_writer #(
    parameter int TOTAL_W    = 5,
    parameter int GLYPH_W    = 5,
    parameter int BLANK_CODE = 20
) (
    input  wire logic                     clock_100Mhz,
    input  wire logic                     reset,
    blackjack_display_writer_if.master    disp
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CONV  = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [GLYPH_W-1:0] c_blank = GLYPH_W'(BLANK_CODE);
    localparam logic [GLYPH_W-1:0] c_r     = GLYPH_W'(10);
    localparam logic [GLYPH_W-1:0] c_e     = GLYPH_W'(11);
    localparam logic [GLYPH_W-1:0] c_a     = GLYPH_W'(12);
    localparam logic [GLYPH_W-1:0] c_d     = GLYPH_W'(13);
    localparam logic [GLYPH_W-1:0] c_y     = GLYPH_W'(14);
    localparam logic [GLYPH_W-1:0] c_u     = GLYPH_W'(15);
    localparam logic [GLYPH_W-1:0] c_l     = GLYPH_W'(16);
    localparam logic [GLYPH_W-1:0] c_w     = GLYPH_W'(17);
    localparam logic [GLYPH_W-1:0] c_n     = GLYPH_W'(18);
    localparam logic [GLYPH_W-1:0] c_t     = GLYPH_W'(19);
    localparam logic [GLYPH_W-1:0] c_qm    = GLYPH_W'(21);

    state_t             state_q,    state_d;
    logic [1:0]         conv_cnt_q, conv_cnt_d;
    logic [2:0]         msg_q,      msg_d;
    logic [TOTAL_W-1:0] p_rem_q,    p_rem_d;
    logic [TOTAL_W-1:0] d_rem_q,    d_rem_d;
    // Totals top out at 31, so the tens digit never exceeds 3.
    logic [1:0]         p_tens_q,   p_tens_d;
    logic [1:0]         d_tens_q,   d_tens_d;
    logic               busy_q,     busy_d;
    logic               done_q,     done_d;
    logic               wr_en_q,    wr_en_d;
    logic [2:0]         wr_addr_q,  wr_addr_d;
    logic [GLYPH_W-1:0] wr_data_q,  wr_data_d;

    logic               w_p_ge10, w_d_ge10;
    logic [TOTAL_W-1:0] w_p_rem_step, w_d_rem_step;
    logic [1:0]         w_p_tens_step, w_d_tens_step;

    // Glyph for one slot of the selected message; SCORE blanks a zero tens digit.
    function automatic logic [GLYPH_W-1:0] glyph_for(
        input logic [2:0] msg,
        input logic [2:0] slot,
        input logic [1:0] p_tens,
        input logic [3:0] p_units,
        input logic [1:0] d_tens,
        input logic [3:0] d_units
    );
        logic [GLYPH_W-1:0] g;
        g = c_blank;
        case (msg)
            3'd0: case (slot)                       // b b R E A D Y ?
                3'd2: g = c_r;
                3'd3: g = c_e;
                3'd4: g = c_a;
                3'd5: g = c_d;
                3'd6: g = c_y;
                3'd7: g = c_qm;
                default: g = c_blank;
            endcase
            3'd1: case (slot)                       // Pt Pu b b b b Dt Du
                3'd0: g = (p_tens == 2'd0) ? c_blank : GLYPH_W'(p_tens);
                3'd1: g = GLYPH_W'(p_units);
                3'd6: g = (d_tens == 2'd0) ? c_blank : GLYPH_W'(d_tens);
                3'd7: g = GLYPH_W'(d_units);
                default: g = c_blank;
            endcase
            3'd2: case (slot)                       // b b b b b W 1 N
                3'd5: g = c_w;
                3'd6: g = GLYPH_W'(1);
                3'd7: g = c_n;
                default: g = c_blank;
            endcase
            3'd3: case (slot)                       // b b b b L 0 5 E
                3'd4: g = c_l;
                3'd5: g = GLYPH_W'(0);
                3'd6: g = GLYPH_W'(5);
                3'd7: g = c_e;
                default: g = c_blank;
            endcase
            3'd4: case (slot)                       // b b b b 8 U 5 T
                3'd4: g = GLYPH_W'(8);
                3'd5: g = c_u;
                3'd6: g = GLYPH_W'(5);
                3'd7: g = c_t;
                default: g = c_blank;
            endcase
            3'd5: case (slot)                       // b b b b b T 1 E
                3'd5: g = c_t;
                3'd6: g = GLYPH_W'(1);
                3'd7: g = c_e;
                default: g = c_blank;
            endcase
            default: g = c_blank;
        endcase
        return g;
    endfunction

    // One subtract-10 step for each total, used on every CONV edge.
    always_comb begin
        w_p_ge10      = (p_rem_q >= TOTAL_W'(10));
        w_d_ge10      = (d_rem_q >= TOTAL_W'(10));
        w_p_rem_step  = w_p_ge10 ? (p_rem_q - TOTAL_W'(10)) : p_rem_q;
        w_d_rem_step  = w_d_ge10 ? (d_rem_q - TOTAL_W'(10)) : d_rem_q;
        w_p_tens_step = p_tens_q + {1'b0, w_p_ge10};
        w_d_tens_step = d_tens_q + {1'b0, w_d_ge10};
    end

    // Next-state and registered-output logic for the request sequencer.
    always_comb begin
        state_d    = state_q;
        conv_cnt_d = conv_cnt_q;
        msg_d      = msg_q;
        p_rem_d    = p_rem_q;
        d_rem_d    = d_rem_q;
        p_tens_d   = p_tens_q;
        d_tens_d   = d_tens_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        wr_en_d    = 1'b0;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = c_blank;

        case (state_q)
            // DONE accepts a new request on its exit edge, so a requester can
            // start the next message without an extra idle cycle.
            ST_IDLE, ST_DONE: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
                if (disp.req) begin
                    state_d    = ST_CONV;
                    busy_d     = 1'b1;
                    conv_cnt_d = 2'd0;
                    msg_d      = disp.msg_sel;
                    p_rem_d    = disp.player_total;
                    d_rem_d    = disp.dealer_total;
                    p_tens_d   = 2'd0;
                    d_tens_d   = 2'd0;
                end
            end
            ST_CONV: begin
                p_rem_d    = w_p_rem_step;
                d_rem_d    = w_d_rem_step;
                p_tens_d   = w_p_tens_step;
                d_tens_d   = w_d_tens_step;
                conv_cnt_d = conv_cnt_q + 2'd1;
                if (conv_cnt_q == 2'd2) begin
                    // Last step: slot 0 goes out using the final digits.
                    state_d   = ST_WRITE;
                    wr_en_d   = 1'b1;
                    wr_addr_d = 3'd0;
                    wr_data_d = glyph_for(msg_q, 3'd0, w_p_tens_step, w_p_rem_step[3:0],
                                          w_d_tens_step, w_d_rem_step[3:0]);
                end
            end
            ST_WRITE: begin
                if (wr_addr_q == 3'd7) begin
                    state_d   = ST_DONE;
                    done_d    = 1'b1;
                    wr_addr_d = 3'd0;
                end else begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = wr_addr_q + 3'd1;
                    wr_data_d = glyph_for(msg_q, wr_addr_q + 3'd1, p_tens_q, p_rem_q[3:0],
                                          d_tens_q, d_rem_q[3:0]);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and output registers; reset aborts any request in flight.
    always_ff @(posedge clock_100Mhz or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            conv_cnt_q <= 2'd0;
            msg_q      <= 3'd0;
            p_rem_q    <= '0;
            d_rem_q    <= '0;
            p_tens_q   <= 2'd0;
            d_tens_q   <= 2'd0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= 3'd0;
            wr_data_q  <= c_blank;
        end else begin
            state_q    <= state_d;
            conv_cnt_q <= conv_cnt_d;
            msg_q      <= msg_d;
            p_rem_q    <= p_rem_d;
            d_rem_q    <= d_rem_d;
            p_tens_q   <= p_tens_d;
            d_tens_q   <= d_tens_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            wr_en_q    <= wr_en_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
        end
    end

    assign disp.busy    = busy_q;
    assign disp.done    = done_q;
    assign disp.wr_en   = wr_en_q;
    assign disp.wr_addr = wr_addr_q;
    assign disp.wr_data = wr_data_q;

endmodule
`default_nettype wire

// File: tb/tb_blackjack_display_writer.sv
`default_nettype none
// ============================================================================
// Module      : tb_blackjack_display_writer
// Description : Directed self-checking bench for blackjack_display_writer.
//               Each request is captured for 14 cycles after acceptance and
//               checked against hand-computed glyph sequences and timing.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_blackjack_display_writer;

    logic clk;
    logic rst;
    int   vectors;
    int   miscompares;

    // Per-cycle capture; index k = sample after edge E(k).
    logic       cap_en   [0:13];
    logic [2:0] cap_addr [0:13];
    logic [4:0] cap_data [0:13];
    logic       cap_busy [0:13];
    logic       cap_done [0:13];

    blackjack_display_writer_if #(.TOTAL_W(5), .GLYPH_W(5)) bus ();

    blackjack_display_writer #(
        .TOTAL_W   (5),
        .GLYPH_W   (5),
        .BLANK_CODE(20)
    ) dut (
        .clock_100Mhz(clk),
        .reset       (rst),
        .disp        (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issue one request, optionally pulse req again while busy, and capture
    // outputs on the falling edge of each of the following 14 cycles.
    task automatic run_req(input logic [2:0] m, input logic [4:0] p, input logic [4:0] d,
                           input int pulse_at);
        @(negedge clk);
        bus.msg_sel      = m;
        bus.player_total = p;
        bus.dealer_total = d;
        bus.req          = 1'b1;
        @(posedge clk);
        for (int k = 0; k < 14; k++) begin
            @(negedge clk);
            cap_en[k]   = bus.wr_en;
            cap_addr[k] = bus.wr_addr;
            cap_data[k] = bus.wr_data;
            cap_busy[k] = bus.busy;
            cap_done[k] = bus.done;
            bus.req          = (k == pulse_at);
            bus.msg_sel      = 3'(k + 1);
            bus.player_total = 5'(k * 7);
            bus.dealer_total = 5'(k * 3 + 1);
        end
        bus.req = 1'b0;
    endtask

    task automatic test_reset();
        rst     = 1'b1;
        bus.req = 1'b0;
        bus.msg_sel = 3'd0;
        bus.player_total = 5'd0;
        bus.dealer_total = 5'd0;
        repeat (2) @(negedge clk);
        vectors++;
        if (bus.wr_en !== 1'b0 || bus.busy !== 1'b0 || bus.done !== 1'b0 ||
            bus.wr_addr !== 3'd0 || bus.wr_data !== 5'd20) begin
            miscompares++;
            $display("FAIL reset_values: got en=%b busy=%b done=%b addr=%0d data=%0d want 0 0 0 0 20",
                     bus.wr_en, bus.busy, bus.done, bus.wr_addr, bus.wr_data);
        end
        rst = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            vectors++;
            if (bus.wr_en !== 1'b0 || bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.wr_data !== 5'd20) begin
                miscompares++;
                $display("FAIL idle_cycle_%0d: got en=%b busy=%b done=%b data=%0d want 0 0 0 20",
                         k, bus.wr_en, bus.busy, bus.done, bus.wr_data);
            end
        end
    endtask

    task automatic test_score();
        logic [4:0] tp [3];
        logic [4:0] td [3];
        logic [4:0] te [3][8];
        logic       exp_en;
        tp[0] = 5'd21; td[0] = 5'd17;
        tp[1] = 5'd31; td[1] = 5'd5;
        tp[2] = 5'd0;  td[2] = 5'd10;
        te[0] = '{5'd2,  5'd1, 5'd20, 5'd20, 5'd20, 5'd20, 5'd1,  5'd7};
        te[1] = '{5'd3,  5'd1, 5'd20, 5'd20, 5'd20, 5'd20, 5'd20, 5'd5};
        te[2] = '{5'd20, 5'd0, 5'd20, 5'd20, 5'd20, 5'd20, 5'd1,  5'd0};
        for (int c = 0; c < 3; c++) begin
            run_req(3'd1, tp[c], td[c], -1);
            for (int k = 0; k < 14; k++) begin
                exp_en = (k >= 3 && k <= 10);
                vectors++;
                if (cap_en[k] !== exp_en) begin
                    miscompares++;
                    $display("FAIL score%0d_wr_en cyc %0d: got %b want %b", c, k, cap_en[k], exp_en);
                end
                if (exp_en) begin
                    vectors++;
                    if (cap_addr[k] !== 3'(k - 3) || cap_data[k] !== te[c][k-3]) begin
                        miscompares++;
                        $display("FAIL score%0d_slot cyc %0d: got addr=%0d data=%0d want addr=%0d data=%0d",
                                 c, k, cap_addr[k], cap_data[k], k - 3, te[c][k-3]);
                    end
                end
                vectors++;
                if (cap_done[k] !== (k == 11) || cap_busy[k] !== (k <= 11)) begin
                    miscompares++;
                    $display("FAIL score%0d_done_busy cyc %0d: got done=%b busy=%b want done=%b busy=%b",
                             c, k, cap_done[k], cap_busy[k], (k == 11), (k <= 11));
                end
            end
        end
    endtask

    task automatic test_ready_req_while_busy();
        logic [4:0] te [8];
        logic       exp_en;
        int         writes;
        te = '{5'd20, 5'd20, 5'd10, 5'd11, 5'd12, 5'd13, 5'd14, 5'd21};
        writes = 0;
        run_req(3'd0, 5'd0, 5'd0, 4);      // req high again across E5
        for (int k = 0; k < 14; k++) begin
            exp_en = (k >= 3 && k <= 10);
            if (cap_en[k] === 1'b1) writes++;
            vectors++;
            if (cap_en[k] !== exp_en) begin
                miscompares++;
                $display("FAIL ready_wr_en cyc %0d: got %b want %b", k, cap_en[k], exp_en);
            end
            if (exp_en) begin
                vectors++;
                if (cap_addr[k] !== 3'(k - 3) || cap_data[k] !== te[k-3]) begin
                    miscompares++;
                    $display("FAIL ready_slot cyc %0d: got addr=%0d data=%0d want addr=%0d data=%0d",
                             k, cap_addr[k], cap_data[k], k - 3, te[k-3]);
                end
            end
            vectors++;
            if (cap_done[k] !== (k == 11) || cap_busy[k] !== (k <= 11)) begin
                miscompares++;
                $display("FAIL ready_done_busy cyc %0d: got done=%b busy=%b want done=%b busy=%b",
                         k, cap_done[k], cap_busy[k], (k == 11), (k <= 11));
            end
        end
        vectors++;
        if (writes != 8) begin
            miscompares++;
            $display("FAIL ready_write_count: got %0d want 8", writes);
        end
    endtask

    task automatic test_messages();
        logic [2:0] tm [4];
        logic [4:0] te [4][8];
        tm[0] = 3'd3; te[0] = '{5'd20, 5'd20, 5'd20, 5'd20, 5'd16, 5'd0,  5'd5,  5'd11};
        tm[1] = 3'd4; te[1] = '{5'd20, 5'd20, 5'd20, 5'd20, 5'd8,  5'd15, 5'd5,  5'd19};
        tm[2] = 3'd5; te[2] = '{5'd20, 5'd20, 5'd20, 5'd20, 5'd20, 5'd19, 5'd1,  5'd11};
        tm[3] = 3'd6; te[3] = '{5'd20, 5'd20, 5'd20, 5'd20, 5'd20, 5'd20, 5'd20, 5'd20};
        for (int c = 0; c < 4; c++) begin
            run_req(tm[c], 5'd25, 5'd19, -1);
            for (int k = 3; k <= 10; k++) begin
                vectors++;
                if (cap_en[k] !== 1'b1 || cap_addr[k] !== 3'(k - 3) || cap_data[k] !== te[c][k-3]) begin
                    miscompares++;
                    $display("FAIL msg%0d_slot cyc %0d: got en=%b addr=%0d data=%0d want en=1 addr=%0d data=%0d",
                             tm[c], k, cap_en[k], cap_addr[k], cap_data[k], k - 3, te[c][k-3]);
                end
            end
            vectors++;
            if (cap_en[11] !== 1'b0 || cap_done[11] !== 1'b1) begin
                miscompares++;
                $display("FAIL msg%0d_done: got en=%b done=%b want en=0 done=1", tm[c], cap_en[11], cap_done[11]);
            end
        end
    endtask

    task automatic test_reset_mid_op();
        logic [4:0] te [8];
        logic       exp_en;
        te = '{5'd20, 5'd20, 5'd20, 5'd20, 5'd20, 5'd17, 5'd1, 5'd18};
        @(negedge clk);
        bus.msg_sel = 3'd3;
        bus.player_total = 5'd12;
        bus.dealer_total = 5'd20;
        bus.req = 1'b1;
        @(posedge clk);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            bus.req = 1'b0;
        end
        vectors++;
        if (bus.wr_en !== 1'b1 || bus.wr_addr !== 3'd2 || bus.wr_data !== 5'd20) begin
            miscompares++;
            $display("FAIL lose_third_write: got en=%b addr=%0d data=%0d want en=1 addr=2 data=20",
                     bus.wr_en, bus.wr_addr, bus.wr_data);
        end
        rst = 1'b1;
        #1;
        vectors++;
        if (bus.wr_en !== 1'b0 || bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.wr_data !== 5'd20) begin
            miscompares++;
            $display("FAIL abort_immediate: got en=%b busy=%b done=%b data=%0d want 0 0 0 20",
                     bus.wr_en, bus.busy, bus.done, bus.wr_data);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            vectors++;
            if (bus.wr_en !== 1'b0 || bus.done !== 1'b0 || bus.busy !== 1'b0) begin
                miscompares++;
                $display("FAIL abort_quiet cyc %0d: got en=%b done=%b busy=%b want 0 0 0",
                         k, bus.wr_en, bus.done, bus.busy);
            end
        end
        run_req(3'd2, 5'd9, 5'd30, -1);
        for (int k = 0; k < 14; k++) begin
            exp_en = (k >= 3 && k <= 10);
            vectors++;
            if (cap_en[k] !== exp_en) begin
                miscompares++;
                $display("FAIL win_wr_en cyc %0d: got %b want %b", k, cap_en[k], exp_en);
            end
            if (exp_en) begin
                vectors++;
                if (cap_addr[k] !== 3'(k - 3) || cap_data[k] !== te[k-3]) begin
                    miscompares++;
                    $display("FAIL win_slot cyc %0d: got addr=%0d data=%0d want addr=%0d data=%0d",
                             k, cap_addr[k], cap_data[k], k - 3, te[k-3]);
                end
            end
            vectors++;
            if (cap_done[k] !== (k == 11)) begin
                miscompares++;
                $display("FAIL win_done cyc %0d: got %b want %b", k, cap_done[k], (k == 11));
            end
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        test_reset();
        test_score();
        test_ready_req_while_busy();
        test_messages();
        test_reset_mid_op();
        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
